// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 3-bit-opcode mini-ISA over a shared instruction/data
// memory. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and halts on a memory timeout.
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             i_or_d_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_control_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             illegal_o,
    output logic             bus_error_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpAddi = 3'd1;
    localparam logic [2:0] OpSub  = 3'd2;
    localparam logic [2:0] OpLw   = 3'd3;
    localparam logic [2:0] OpSw   = 3'd4;
    localparam logic [2:0] OpBeq  = 3'd5;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    state_e             state_q;
    logic [WaitW-1:0]   wait_q;
    logic [CNT_W-1:0]   count_q;
    logic               bus_error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            count_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    wait_q  <= '0;
                end
                StFetch, StMem: begin
                    if (mem_ready_i) begin
                        wait_q <= '0;
                        if (state_q == StFetch) begin
                            state_q <= StDecode;
                        end else if (opcode_i == OpSw) begin
                            state_q <= StFetch;
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (wait_q == WaitW'(TIMEOUT)) begin
                        // Limit reached with no ready: the access is abandoned for good.
                        state_q     <= StHalt;
                        bus_error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StDecode: state_q <= StExec;
                StExec: begin
                    wait_q <= '0;
                    case (opcode_i)
                        OpAdd, OpAddi, OpSub: state_q <= StWb;
                        OpLw, OpSw:           state_q <= StMem;
                        default: begin
                            // BEQ and undefined opcodes both retire straight from EXEC.
                            state_q <= StFetch;
                            count_q <= count_q + CNT_W'(1);
                        end
                    endcase
                end
                StWb: begin
                    state_q <= StFetch;
                    wait_q  <= '0;
                    count_q <= count_q + CNT_W'(1);
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_req_o     = 1'b0;
        i_or_d_o      = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_src_o      = 1'b0;
        alu_src_o     = 1'b0;
        alu_control_o = 2'd0;
        reg_write_o   = 1'b0;
        mem_to_reg_o  = 1'b0;
        illegal_o     = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                end
            end
            StExec: begin
                case (opcode_i)
                    OpAdd:              alu_src_o = 1'b0;
                    OpAddi, OpLw, OpSw: alu_src_o = 1'b1;
                    OpSub:              alu_control_o = 2'd1;
                    OpBeq: begin
                        alu_control_o = 2'd1;
                        if (zero_i) begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 1'b1;
                        end
                    end
                    default:            illegal_o = 1'b1;
                endcase
            end
            StMem: begin
                mem_req_o   = 1'b1;
                i_or_d_o    = 1'b1;
                mem_write_o = (opcode_i == OpSw);
            end
            StWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (opcode_i == OpLw);
            end
            default: ;
        endcase
    end

    assign bus_error_o   = bus_error_q;
    assign instr_count_o = count_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction is expanded from the ISA rules
// into an expected per-cycle trace (state, enables, memory-ready drive) and replayed cycle by cycle.
module tb_multicycle_control_fsm;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    localparam logic [11:0] MREQ = 12'h800;
    localparam logic [11:0] IORD = 12'h400;
    localparam logic [11:0] MWR  = 12'h200;
    localparam logic [11:0] IRW  = 12'h100;
    localparam logic [11:0] PCW  = 12'h080;
    localparam logic [11:0] PCS  = 12'h040;
    localparam logic [11:0] ASRC = 12'h020;
    localparam logic [11:0] ASUB = 12'h008;
    localparam logic [11:0] RW   = 12'h004;
    localparam logic [11:0] M2R  = 12'h002;
    localparam logic [11:0] ILL  = 12'h001;

    typedef struct packed {
        logic [2:0]  st;
        logic        rdy;
        logic [11:0] outs;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    opcode = 3'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, i_or_d, mem_write, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]    alu_control;
    logic          reg_write, mem_to_reg, illegal, bus_error;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;
    logic [11:0]   obs;

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] model_count = '0;
    cyc_t          trace[$];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode_i      (opcode),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .mem_req_o     (mem_req),
        .i_or_d_o      (i_or_d),
        .mem_write_o   (mem_write),
        .ir_write_o    (ir_write),
        .pc_write_o    (pc_write),
        .pc_src_o      (pc_src),
        .alu_src_o     (alu_src),
        .alu_control_o (alu_control),
        .reg_write_o   (reg_write),
        .mem_to_reg_o  (mem_to_reg),
        .illegal_o     (illegal),
        .bus_error_o   (bus_error),
        .state_o       (state),
        .instr_count_o (instr_count)
    );

    assign obs = {mem_req, i_or_d, mem_write, ir_write, pc_write, pc_src, alu_src, alu_control,
                  reg_write, mem_to_reg, illegal};

    function automatic void push(input logic [2:0] st, input logic rdy, input logic [11:0] o);
        cyc_t c;
        c.st   = st;
        c.rdy  = rdy;
        c.outs = o;
        trace.push_back(c);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, starting in FETCH.
    function automatic void build_trace(input logic [2:0] op, input logic z, input int fw,
                                        input int mw);
        logic [11:0] eo;
        logic [11:0] mo;
        trace.delete();
        for (int i = 0; i < fw; i++) push(3'd1, 1'b0, MREQ);
        push(3'd1, 1'b1, MREQ | IRW | PCW);
        push(3'd2, 1'($urandom), 12'h000);
        case (op)
            3'd0:       eo = 12'h000;
            3'd1:       eo = ASRC;
            3'd2:       eo = ASUB;
            3'd3, 3'd4: eo = ASRC;
            3'd5:       eo = z ? (ASUB | PCW | PCS) : ASUB;
            default:    eo = ILL;
        endcase
        push(3'd3, 1'($urandom), eo);
        if (op == 3'd3 || op == 3'd4) begin
            mo = (op == 3'd4) ? (MREQ | IORD | MWR) : (MREQ | IORD);
            for (int i = 0; i < mw; i++) push(3'd4, 1'b0, mo);
            push(3'd4, 1'b1, mo);
            if (op == 3'd3) push(3'd5, 1'($urandom), RW | M2R);
        end else if (op <= 3'd2) begin
            push(3'd5, 1'($urandom), RW);
        end
    endfunction

    task automatic play(input int n, input logic [2:0] op, input logic z);
        for (int i = 0; i < n; i++) begin
            opcode    = (trace[i].st == 3'd1) ? 3'($urandom) : op;
            zero      = (trace[i].st == 3'd3) ? z : 1'($urandom);
            mem_ready = trace[i].rdy;
            @(negedge clk);
            checks++;
            if (state !== trace[i].st) begin
                errors++;
                $display("FAIL state op%0d cyc%0d: got %0d want %0d", op, i, state, trace[i].st);
            end
            checks++;
            if (obs !== trace[i].outs) begin
                errors++;
                $display("FAIL enables op%0d cyc%0d: got %h want %h", op, i, obs, trace[i].outs);
            end
            checks++;
            if (instr_count !== model_count) begin
                errors++;
                $display("FAIL instr_count op%0d cyc%0d: got %0d want %0d", op, i, instr_count,
                         model_count);
            end
            checks++;
            if (bus_error !== 1'b0) begin
                errors++;
                $display("FAIL bus_error op%0d cyc%0d: got %b want 0", op, i, bus_error);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z, input int fw, input int mw);
        build_trace(op, z, fw, mw);
        play(trace.size(), op, z);
        model_count = model_count + 1'b1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 3'($urandom);
        zero      = 1'($urandom);
        #1;
        checks++;
        if (state !== 3'd0 || obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: state %0d enables %h, want 0 and 000", state, obs);
        end
        checks++;
        if (instr_count !== '0 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: count %0d bus_error %b, want 0 0", instr_count, bus_error);
        end
        @(posedge clk);
        #1;
        checks++;
        if (state !== 3'd0 || obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_held: state %0d enables %h, want 0 and 000", state, obs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || obs !== 12'h000) begin
            errors++;
            $display("FAIL idle: state %0d enables %h, want 0 and 000", state, obs);
        end
        @(posedge clk);
        #1;
        model_count = '0;
    endtask

    task automatic timeout_phase(input logic [2:0] st, input logic [11:0] o, input logic [2:0] op);
        for (int i = 0; i <= int'(TO); i++) begin
            opcode    = op;
            zero      = 1'($urandom);
            mem_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (state !== st || obs !== o || bus_error !== 1'b0) begin
                errors++;
                $display("FAIL wait cyc%0d: state %0d enables %h berr %b, want %0d %h 0",
                         i, state, obs, bus_error, st, o);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            opcode    = 3'($urandom);
            zero      = 1'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (state !== 3'd6 || obs !== 12'h000 || bus_error !== 1'b1) begin
                errors++;
                $display("FAIL halt cyc%0d: state %0d enables %h berr %b, want 6 000 1",
                         i, state, obs, bus_error);
            end
            checks++;
            if (instr_count !== model_count) begin
                errors++;
                $display("FAIL halt_count: got %0d want %0d", instr_count, model_count);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_add();
        run_instr(3'd0, 1'($urandom), 0, 0);
    endtask

    task automatic test_lw();
        run_instr(3'd3, 1'($urandom), 2, 1);
    endtask

    task automatic test_sw();
        run_instr(3'd4, 1'($urandom), 0, 0);
    endtask

    task automatic test_beq();
        run_instr(3'd5, 1'b1, 0, 0);
        run_instr(3'd5, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr(3'd6, 1'($urandom), 0, 0);
        run_instr(3'd7, 1'($urandom), 1, 0);
    endtask

    task automatic test_boundary();
        run_instr(3'd0, 1'b0, TO, 0);
        run_instr(3'd3, 1'b0, TO, TO);
        run_instr(3'd4, 1'b0, 0, TO);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_instr(3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, TO),
                      $urandom_range(0, TO));
        end
    endtask

    task automatic test_abort();
        build_trace(3'd0, 1'b0, 0, 0);
        play(3, 3'd0, 1'b0);
        apply_reset();
    endtask

    task automatic test_timeout_fetch();
        run_instr(3'd1, 1'b0, 0, 0);
        timeout_phase(3'd1, MREQ, 3'($urandom));
        apply_reset();
    endtask

    task automatic test_timeout_mem();
        build_trace(3'd3, 1'b0, 0, 0);
        play(3, 3'd3, 1'b0);
        timeout_phase(3'd4, MREQ | IORD, 3'd3);
        apply_reset();
        run_instr(3'd2, 1'b0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        #2;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_beq();
        test_illegal();
        test_boundary();
        test_random();
        test_abort();
        test_timeout_fetch();
        test_timeout_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the 3-bit-opcode mini-ISA: 0 ADD, 1 ADDI, 2 SUB, 3 LW, 4 SW, 5 BEQ.
- Replaces the single-cycle decoder in the shared-memory CPU variant.
- Steps one instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory with a req/ready handshake.
- Drives PC, IR, ALU, register-file and memory enables; counts retired instructions; halts on memory timeout.

Parameters:
- TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus error (≥1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  3  IR[opcode] field; stable from DECODE until the next FETCH.
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  write strobe, qualifies mem_req.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  1  PC source: 0 = PC+1, 1 = branch target.
- alu_src  out  1  ALU B operand: 0 = register, 1 = immediate.
- alu_control  out  2  ALU op: 0 = add, 1 = sub.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback select: 1 = memory data.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- bus_error  out  1  sticky memory-timeout flag.
- state  out  3  current state encoding, for debug.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and recovers to IDLE.
- Reset (async, rst_n low):
  - state=IDLE, wait counter=0, instr_count=0, bus_error=0.
  - All outputs 0 while in reset and in IDLE.
- Outputs are combinational from state, opcode, zero and mem_ready. Every output not listed for a state is 0.
- IDLE: go to FETCH on the next cycle.
- FETCH:
  - mem_req=1, i_or_d=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0 in that same cycle; go to DECODE. Otherwise stay in FETCH.
- DECODE: no enables; go to EXEC.
- EXEC, by opcode:
  - 0 (ADD): alu_src=0, alu_control=0; go to WB.
  - 1 (ADDI): alu_src=1, alu_control=0; go to WB.
  - 2 (SUB): alu_src=0, alu_control=1; go to WB.
  - 3 (LW), 4 (SW): alu_src=1, alu_control=0; go to MEM.
  - 5 (BEQ): alu_src=0, alu_control=1. If zero=1: pc_write=1, pc_src=1. Retire and go to FETCH.
  - 6, 7: illegal=1, retire as a NOP, go to FETCH.
- MEM:
  - mem_req=1, i_or_d=1, mem_write=(opcode==4).
  - When mem_ready=1: LW goes to WB; SW retires and goes to FETCH. Otherwise stay in MEM.
- WB: reg_write=1, mem_to_reg=(opcode==3); retire and go to FETCH.
- Retire: instr_count increments by 1 on the clock edge leaving the retiring state. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - ADD/ADDI/SUB: 4 cycles. LW: 5. SW: 4. BEQ: 3. Illegal: 3.
  - Each wait cycle in FETCH or MEM adds 1.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 with mem_ready=0.
  - If mem_ready is still low once the counter reaches TIMEOUT: set bus_error=1 and go to HALT.
  - mem_ready arriving in the same cycle the limit is reached wins: the access completes and there is no error.
- HALT: all enables 0; bus_error stays 1; leave only via reset.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-instruction aborts immediately: no further enables, no retire, instr_count=0.

Test Plan:
- Reset release, ADD (opcode 0), mem_ready always 1 → IDLE, then FETCH (ir_write=pc_write=1), DECODE, EXEC (alu_control=0, alu_src=0), WB (reg_write=1); instr_count=1 after 5 cycles.
- LW (3) with mem_ready low 2 cycles in FETCH and 1 cycle in MEM → 8 cycles FETCH→FETCH; MEM shows i_or_d=1, mem_write=0; WB shows mem_to_reg=1.
- SW (4) → MEM shows mem_write=1 and mem_req=1; reg_write never asserted; next state FETCH.
- BEQ (5) with zero=1 → EXEC shows pc_write=1, pc_src=1, alu_control=1. Repeat with zero=0 → pc_write=0; both retire in 3 cycles.
- Opcode 6 → illegal=1 for exactly 1 cycle in EXEC, instr_count increments, FETCH follows.
- TIMEOUT=4, mem_ready held low in FETCH → bus_error=1 after 4 wait cycles, state=6, all enables 0. Stays halted. Pulsing rst_n low clears bus_error and instr_count and returns to IDLE.
